// File: rtl/logic_gate_pipe_if.sv
// Operand/result stream bundle for logic_gate_pipe.
// The slave side is the pipeline; the master side is the producer/consumer pair.
interface logic_gate_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             zero;
   logic             all_ones;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, y, zero, all_ones, op_count
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, y, zero, all_ones, op_count
   );
endinterface

// File: rtl/logic_gate_pipe.sv
// Two-stage elastic pipeline computing a selectable bitwise/reduction logic
// function of two WIDTH-bit operands, with registered result flags and a
// saturating count of completed output handshakes.
module logic_gate_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input logic              clk,
   input logic              rst,
   logic_gate_pipe_if.slave bus
);

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NAND = 3'b011,
      OP_NOR  = 3'b100,
      OP_XNOR = 3'b101,
      OP_ANDN = 3'b110,
      OP_RAND = 3'b111
   } op_e;

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   op_e              s1_op_q, s1_op_d;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic             all_ones_q, all_ones_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             s2_adv;
   logic             s1_adv;
   logic             out_hs;
   logic [WIDTH-1:0] func;

   // Ready chain: a stage may load when it is empty or its contents move on.
   // in_ready depends on out_ready and stage occupancy only, never on in_valid.
   always_comb begin
      s2_adv = !s2_valid_q || bus.out_ready;
      s1_adv = !s1_valid_q || s2_adv;
      out_hs = s2_valid_q && bus.out_ready;
   end

   // Logic function evaluated on the stage-1 operands.
   always_comb begin
      func = '0;
      case (s1_op_q)
         OP_AND:  func = s1_a_q & s1_b_q;
         OP_OR:   func = s1_a_q | s1_b_q;
         OP_XOR:  func = s1_a_q ^ s1_b_q;
         OP_NAND: func = ~(s1_a_q & s1_b_q);
         OP_NOR:  func = ~(s1_a_q | s1_b_q);
         OP_XNOR: func = ~(s1_a_q ^ s1_b_q);
         OP_ANDN: func = s1_a_q & ~s1_b_q;
         OP_RAND: func[0] = &(s1_a_q & s1_b_q);
         default: func = '0;
      endcase
   end

   // Next-state for both stages and the counter. Data registers only load
   // alongside a valid beat so y and the flags keep their last value when
   // the output stage drains empty.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s2_valid_d = s2_valid_q;
      y_d        = y_q;
      zero_d     = zero_q;
      all_ones_d = all_ones_q;
      cnt_d      = cnt_q;

      if (s1_adv) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_a_d  = bus.a;
            s1_b_d  = bus.b;
            s1_op_d = op_e'(bus.op);
         end
      end

      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            y_d        = func;
            zero_d     = (func == '0);
            all_ones_d = (func == '1);
         end
      end

      if (out_hs && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers; synchronous reset drops any in-flight beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= OP_AND;
         s2_valid_q <= 1'b0;
         y_q        <= '0;
         zero_q     <= 1'b0;
         all_ones_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_op_q    <= s1_op_d;
         s2_valid_q <= s2_valid_d;
         y_q        <= y_d;
         zero_q     <= zero_d;
         all_ones_q <= all_ones_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = s2_valid_q;
   assign bus.y         = y_q;
   assign bus.zero      = zero_q;
   assign bus.all_ones  = all_ones_q;
   assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: directed scenarios plus random streaming,
// checked against a queue-based transaction model.
module tb_logic_gate_pipe;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic_gate_pipe_if #(.WIDTH(W), .CNT_W(16)) bus ();
   logic_gate_pipe_if #(.WIDTH(W), .CNT_W(2))  bus2 ();

   assign bus2.in_valid  = bus.in_valid;
   assign bus2.a         = bus.a;
   assign bus2.b         = bus.b;
   assign bus2.op        = bus.op;
   assign bus2.out_ready = bus.out_ready;

   logic_gate_pipe #(.WIDTH(W), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic_gate_pipe #(.WIDTH(W), .CNT_W(2)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   typedef struct {
      logic [W-1:0] y;
      int unsigned  edge_no;
   } beat_t;

   beat_t        q[$];
   logic [W-1:0] seen[$];
   int unsigned  edge_cnt = 0;
   int unsigned  hs_total = 0;
   int           errors = 0;
   int           checks = 0;

   function automatic logic [W-1:0] ref_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
      logic [W-1:0] ones;
      ones = '1;
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ones - (a & b);
         3'd4: return ones - (a | b);
         3'd5: return ones - (a ^ b);
         3'd6: return a & (ones - b);
         default: return ((a & b) == ones) ? W'(1) : W'(0);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      logic exp_ov;
      exp_ov = (q.size() > 0) && (q[0].edge_no < edge_cnt);
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (exp_ov) begin
         chk("y", 32'(bus.y), 32'(q[0].y));
         chk("zero", 32'(bus.zero), 32'(q[0].y == '0));
         chk("all_ones", 32'(bus.all_ones), 32'(q[0].y == '1));
      end
      chk("op_count", 32'(bus.op_count), 32'(hs_total));
      chk("op_count_sat", 32'(bus2.op_count), (hs_total > 3) ? 32'd3 : 32'(hs_total));
   endtask

   task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [2:0] iop, input logic ordy);
      logic exp_ov, exp_ir, in_hs, out_hs;
      beat_t nb;
      bus.in_valid  = iv;
      bus.a         = ia;
      bus.b         = ib;
      bus.op        = iop;
      bus.out_ready = ordy;
      #1;
      exp_ov = (q.size() > 0) && (q[0].edge_no < edge_cnt);
      exp_ir = (q.size() < 2) || ordy;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
      in_hs  = iv && exp_ir;
      out_hs = exp_ov && ordy;
      @(posedge clk);
      edge_cnt++;
      if (out_hs) begin
         seen.push_back(q[0].y);
         void'(q.pop_front());
         hs_total++;
      end
      if (in_hs) begin
         nb.y       = ref_fn(ia, ib, iop);
         nb.edge_no = edge_cnt;
         q.push_back(nb);
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b1;
      bus.a         = 8'h3C;
      bus.b         = 8'hFF;
      bus.op        = 3'd1;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      edge_cnt++;
      q.delete();
      seen.delete();
      hs_total = 0;
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_y", 32'(bus.y), 32'd0);
      chk("rst_zero", 32'(bus.zero), 32'd0);
      chk("rst_all_ones", 32'(bus.all_ones), 32'd0);
      chk("rst_op_count", 32'(bus.op_count), 32'd0);
      chk("rst_op_count_sat", 32'(bus2.op_count), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] t2_exp [8];
      logic [7:0] t4_exp [3];
      t2_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'h00};
      t4_exp = '{8'h01, 8'h02, 8'h04};

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      do_reset();

      // AND basic, latency 2
      step(1'b1, 8'hF0, 8'hCC, 3'd0, 1'b1);
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_y", 32'(bus.y), 32'hC0);
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      chk("t1_count", 32'(bus.op_count), 32'd1);

      // all ops back-to-back
      seen.delete();
      for (int i = 0; i < 8; i++) step(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      chk("t2_n", 32'(seen.size()), 32'd8);
      for (int i = 0; i < 8 && i < seen.size(); i++) chk("t2_seq", 32'(seen[i]), 32'(t2_exp[i]));
      chk("t2_count", 32'(bus.op_count), 32'd9);
      chk("t5_sat", 32'(bus2.op_count), 32'd3);

      // flags
      step(1'b1, 8'hFF, 8'hFF, 3'd4, 1'b1);
      step(1'b1, 8'h5A, 8'h5A, 3'd5, 1'b1);
      chk("t3_zero", 32'(bus.zero), 32'd1);
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      chk("t3_all_ones", 32'(bus.all_ones), 32'd1);
      chk("t3_y", 32'(bus.y), 32'hFF);
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

      // backpressure
      seen.delete();
      step(1'b1, 8'h01, 8'h01, 3'd0, 1'b0);
      step(1'b1, 8'h02, 8'h02, 3'd0, 1'b0);
      step(1'b1, 8'h04, 8'h04, 3'd0, 1'b0);
      chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
      chk("t4_hold_y", 32'(bus.y), 32'h01);
      step(1'b1, 8'h04, 8'h04, 3'd0, 1'b0);
      chk("t4_hold_y2", 32'(bus.y), 32'h01);
      step(1'b1, 8'h04, 8'h04, 3'd0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      chk("t4_n", 32'(seen.size()), 32'd3);
      for (int i = 0; i < 3 && i < seen.size(); i++) chk("t4_seq", 32'(seen[i]), 32'(t4_exp[i]));

      // random streaming
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      chk("rnd_drained", 32'(q.size()), 32'd0);

      // reset with both stages full
      step(1'b1, 8'h11, 8'h11, 3'd0, 1'b0);
      step(1'b1, 8'h22, 8'h22, 3'd0, 1'b0);
      step(1'b1, 8'h44, 8'h44, 3'd0, 1'b0);
      chk("t6_full", 32'(bus.in_ready), 32'd0);
      do_reset();
      step(1'b1, 8'hA5, 8'h0F, 3'd0, 1'b1);
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      chk("t6_y", 32'(bus.y), 32'h05);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      chk("t6_n", 32'(seen.size()), 32'd1);
      chk("t6_count", 32'(bus.op_count), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
